// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: shared types for the reg_alu_core register-file accumulator.
// Holds the instruction opcode encoding, the S1 pipeline control struct and
// small opcode classification helpers.
package reg_alu_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  // Control part of the S1 pipeline register; operand and address fields are
  // parameter-dependent and live beside it in the top level.
  typedef struct packed {
    logic valid;
    op_t  op;
  } s1_ctrl_t;

  // True for every opcode that produces a register write.
  function automatic logic op_writes(input op_t op);
    logic w;
    case (op)
      OP_ADD:  w = 1'b1;
      OP_SUB:  w = 1'b1;
      OP_LOAD: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  // True for the arithmetic opcodes, the only ones that touch the flags.
  function automatic logic op_sets_flags(input op_t op);
    logic f;
    case (op)
      OP_ADD:  f = 1'b1;
      OP_SUB:  f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/reg_alu_exec.sv
// reg_alu_exec: combinational S2 datapath of reg_alu_core.
// Computes result, carry/borrow and zero for one instruction.
// Optional feature macro: REG_ALU_SAT_EN (saturating ADD/SUB when defined).
module reg_alu_exec
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // Extra top bit holds carry out of the add and borrow out of the subtract.
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Result/flag selection; carry reports the raw carry/borrow even when clamped.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        carry = sum_s[WIDTH];
`ifdef REG_ALU_SAT_EN
        if (sum_s[WIDTH]) begin
          res = '1;
        end else begin
          res = sum_s[WIDTH-1:0];
        end
`else
        res = sum_s[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        carry = diff_s[WIDTH];
`ifdef REG_ALU_SAT_EN
        if (diff_s[WIDTH]) begin
          res = '0;
        end else begin
          res = diff_s[WIDTH-1:0];
        end
`else
        res = diff_s[WIDTH-1:0];
`endif
      end
      OP_LOAD: res = data;
      default: res = '0;
    endcase
    zero = (res == '0);
  end

endmodule

// File: rtl/reg_alu_core.sv
// reg_alu_core: parametrised register-file accumulator with a two-stage
// pipeline (S1 operand latch, S2 execute/write), operand forwarding,
// carry/zero flags, sticky illegal-address flag and a valid/ready handshake.
// Optional feature macro: REG_ALU_SAT_EN (saturating arithmetic in reg_alu_exec).
module reg_alu_core
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int NOUT  = 2,
  parameter int AW    = $clog2(NREGS + NOUT)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  STALL,
  input  logic [1:0]            OP,
  input  logic [AW-1:0]         DST,
  input  logic [AW-1:0]         SRCA,
  input  logic [AW-1:0]         SRCB,
  input  logic [WIDTH-1:0]      DATA,
  output logic [NOUT*WIDTH-1:0] OUT_DATA,
  output logic [NOUT-1:0]       OUT_STB,
  output logic                  FLAG_C,
  output logic                  FLAG_Z,
  output logic                  ERR
);

  localparam int NTOT = NREGS + NOUT;

  // Register file: general registers first, then the output registers.
  logic [WIDTH-1:0] rf_r [NTOT];

  s1_ctrl_t         s1_r;
  logic [AW-1:0]    s1_dst_r;
  logic [WIDTH-1:0] s1_data_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;

  logic [NOUT-1:0]  stb_r;
  logic             flag_c_r;
  logic             flag_z_r;
  logic             err_r;

  logic [WIDTH-1:0] ex_res_s;
  logic             ex_c_s;
  logic             ex_z_s;
  logic             accept_s;
  logic             bad_addr_s;
  logic             s2_we_s;
  logic             s2_flags_s;
  logic [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0] opb_s;
  logic [NOUT-1:0]  stb_next_s;

  function automatic logic src_ok(input logic [AW-1:0] a);
    return int'(a) < NREGS;
  endfunction

  function automatic logic dst_ok(input logic [AW-1:0] a);
    return int'(a) < NTOT;
  endfunction

  reg_alu_exec #(.WIDTH(WIDTH)) u_exec (
    .op    (s1_r.op),
    .a     (s1_a_r),
    .b     (s1_b_r),
    .data  (s1_data_r),
    .res   (ex_res_s),
    .carry (ex_c_s),
    .zero  (ex_z_s)
  );

  assign IN_READY   = !STALL;
  assign accept_s   = IN_VALID && !STALL;
  assign bad_addr_s = !dst_ok(DST) || !src_ok(SRCA) || !src_ok(SRCB);
  assign s2_we_s    = s1_r.valid && op_writes(s1_r.op) && dst_ok(s1_dst_r);
  assign s2_flags_s = s1_r.valid && op_sets_flags(s1_r.op);

  // Operand fetch: forward the S2 result when it targets the register being read.
  always_comb begin
    opa_s = '0;
    opb_s = '0;
    if (src_ok(SRCA)) begin
      if (s2_we_s && (s1_dst_r == SRCA)) begin
        opa_s = ex_res_s;
      end else begin
        opa_s = rf_r[SRCA];
      end
    end else begin
      opa_s = '0;
    end
    if (src_ok(SRCB)) begin
      if (s2_we_s && (s1_dst_r == SRCB)) begin
        opb_s = ex_res_s;
      end else begin
        opb_s = rf_r[SRCB];
      end
    end else begin
      opb_s = '0;
    end
  end

  // Strobe for each output register written by the S2 stage this cycle.
  always_comb begin
    stb_next_s = '0;
    for (int i = 0; i < NOUT; i++) begin
      stb_next_s[i] = s2_we_s && (int'(s1_dst_r) == NREGS + i);
    end
  end

  // Pipeline, register file, flags and sticky error; STALL freezes everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_r      <= '0;
      s1_dst_r  <= '0;
      s1_data_r <= '0;
      s1_a_r    <= '0;
      s1_b_r    <= '0;
      for (int i = 0; i < NTOT; i++) begin
        rf_r[i] <= '0;
      end
      stb_r     <= '0;
      flag_c_r  <= 1'b0;
      flag_z_r  <= 1'b0;
      err_r     <= 1'b0;
    end else if (!STALL) begin
      s1_r.valid <= accept_s;
      s1_r.op    <= op_t'(OP);
      s1_dst_r   <= DST;
      s1_data_r  <= DATA;
      s1_a_r     <= opa_s;
      s1_b_r     <= opb_s;
      if (s2_we_s) begin
        rf_r[s1_dst_r] <= ex_res_s;
      end
      stb_r <= stb_next_s;
      if (s2_flags_s) begin
        flag_c_r <= ex_c_s;
        flag_z_r <= ex_z_s;
      end
      if (accept_s && bad_addr_s) begin
        err_r <= 1'b1;
      end
    end else begin
      stb_r <= '0;
    end
  end

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
    assign OUT_DATA[gi*WIDTH +: WIDTH] = rf_r[NREGS + gi];
  end

  // A stall starting right after a write must not leave the strobe visible.
  assign OUT_STB = stb_r & {NOUT{!STALL}};
  assign FLAG_C  = flag_c_r;
  assign FLAG_Z  = flag_z_r;
  assign ERR     = err_r;

endmodule

// File: tb/tb_reg_alu_core.sv
// Self-checking bench for reg_alu_core (WIDTH=8, NREGS=4, NOUT=2).
// The reference is a sequential instruction-set model: each accepted
// instruction executes on the architectural register array one unstalled
// edge after it is accepted. Honours REG_ALU_SAT_EN when defined.
module tb_reg_alu_core;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int NOUT  = 2;
  localparam int AW    = 3;

  logic                  CLK;
  logic                  RST;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic                  STALL;
  logic [1:0]            OP;
  logic [AW-1:0]         DST;
  logic [AW-1:0]         SRCA;
  logic [AW-1:0]         SRCB;
  logic [WIDTH-1:0]      DATA;
  logic [NOUT*WIDTH-1:0] OUT_DATA;
  logic [NOUT-1:0]       OUT_STB;
  logic                  FLAG_C;
  logic                  FLAG_Z;
  logic                  ERR;

  int total = 0;
  int bad   = 0;

  // Architectural model
  logic [7:0] m_reg [6];
  logic [1:0] m_stb;
  logic       m_c, m_z, m_err;
  logic       p_v;
  int         p_op, p_dst, p_sa, p_sb, p_d;

`ifdef REG_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  reg_alu_core #(.WIDTH(WIDTH), .NREGS(NREGS), .NOUT(NOUT)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .STALL(STALL), .OP(OP), .DST(DST), .SRCA(SRCA), .SRCB(SRCB),
    .DATA(DATA), .OUT_DATA(OUT_DATA), .OUT_STB(OUT_STB),
    .FLAG_C(FLAG_C), .FLAG_Z(FLAG_Z), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
    m_stb = 2'b00; m_c = 1'b0; m_z = 1'b0; m_err = 1'b0; p_v = 1'b0;
    p_op = 0; p_dst = 0; p_sa = 0; p_sb = 0; p_d = 0;
  endtask

  task automatic model_exec();
    int a, b, r;
    bit wr;
    a = (p_sa < 4) ? int'(m_reg[p_sa]) : 0;
    b = (p_sb < 4) ? int'(m_reg[p_sb]) : 0;
    r = 0; wr = 1'b0;
    case (p_op)
      1: begin
        r = a + b; m_c = (r > 255);
        if (SAT && r > 255) r = 255;
        r = r % 256; m_z = (r == 0); wr = 1'b1;
      end
      2: begin
        r = a - b; m_c = (a < b);
        if (SAT && a < b) r = 0;
        r = (r + 256) % 256; m_z = (r == 0); wr = 1'b1;
      end
      3: begin r = p_d; wr = 1'b1; end
      default: wr = 1'b0;
    endcase
    if (wr && p_dst < 6) begin
      m_reg[p_dst] = 8'(r);
      if (p_dst >= 4) m_stb[p_dst-4] = 1'b1;
    end
  endtask

  // Model update for one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    m_stb = 2'b00;
    if (!STALL) begin
      if (p_v) model_exec();
      p_v = IN_VALID;
      p_op = int'(OP); p_dst = int'(DST); p_sa = int'(SRCA); p_sb = int'(SRCB); p_d = int'(DATA);
      if (IN_VALID && (DST >= 3'd6 || SRCA >= 3'd4 || SRCB >= 3'd4)) m_err = 1'b1;
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge CLK) begin
    chk("out_data", OUT_DATA, {m_reg[5], m_reg[4]});
    chk("out_stb", OUT_STB, STALL ? 2'b00 : m_stb);
    chk("in_ready", IN_READY, !STALL);
    chk("flag_c", FLAG_C, m_c);
    chk("flag_z", FLAG_Z, m_z);
    chk("err", ERR, m_err);
  end

  task automatic step(input logic v, input logic [1:0] op, input logic [2:0] dst,
                      input logic [2:0] sa, input logic [2:0] sb,
                      input logic [7:0] d, input logic st);
    IN_VALID = v; OP = op; DST = dst; SRCA = sa; SRCB = sb; DATA = d; STALL = st;
    @(posedge CLK);
    if (!RST) model_edge();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    #1;
    chk("rst_out_data", OUT_DATA, 16'h0000);
    chk("rst_out_stb", OUT_STB, 2'b00);
    chk("rst_flags", {FLAG_C, FLAG_Z}, 2'b00);
    chk("rst_err", ERR, 1'b0);
    idle();
    idle();
    RST = 1'b0;
  endtask

  initial begin
    logic       v, st;
    logic [1:0] op;
    logic [2:0] dst, sa, sb;
    logic [7:0] d;
    RST = 1'b0; IN_VALID = 1'b0; STALL = 1'b0; OP = 2'b00;
    DST = 3'd0; SRCA = 3'd0; SRCB = 3'd0; DATA = 8'h00;
    model_reset();
    #2;
    do_reset();

    // Reset and load
    step(1'b1, 2'b11, 3'd0, 3'd0, 3'd0, 8'h05, 1'b0);
    step(1'b1, 2'b11, 3'd1, 3'd0, 3'd0, 8'h03, 1'b0);
    step(1'b1, 2'b01, 3'd4, 3'd0, 3'd1, 8'h00, 1'b0);
    idle();
    chk("t1_out0", OUT_DATA[7:0], 8'h08);
    chk("t1_stb", OUT_STB, 2'b01);
    chk("t1_cz", {FLAG_C, FLAG_Z}, 2'b00);
    idle();
    chk("t1_stb_off", OUT_STB, 2'b00);

    // Forwarding chain with no bubble
    step(1'b1, 2'b11, 3'd0, 3'd0, 3'd0, 8'h10, 1'b0);
    step(1'b1, 2'b01, 3'd1, 3'd0, 3'd0, 8'h00, 1'b0);
    step(1'b1, 2'b01, 3'd4, 3'd1, 3'd2, 8'h00, 1'b0);
    idle();
    chk("fwd_out0", OUT_DATA[7:0], 8'h20);

    // Wrap / saturation
    step(1'b1, 2'b11, 3'd0, 3'd0, 3'd0, 8'hF0, 1'b0);
    step(1'b1, 2'b11, 3'd1, 3'd0, 3'd0, 8'h20, 1'b0);
    step(1'b1, 2'b01, 3'd5, 3'd0, 3'd1, 8'h00, 1'b0);
    idle();
    chk("add_out1", OUT_DATA[15:8], SAT ? 8'hFF : 8'h10);
    chk("add_c", FLAG_C, 1'b1);
    chk("add_z", FLAG_Z, 1'b0);
    step(1'b1, 2'b10, 3'd5, 3'd1, 3'd0, 8'h00, 1'b0);
    idle();
    chk("sub_out1", OUT_DATA[15:8], SAT ? 8'h00 : 8'h30);
    chk("sub_c", FLAG_C, 1'b1);
    chk("sub_z", FLAG_Z, SAT ? 1'b1 : 1'b0);

    // Stall mid-stream
    step(1'b1, 2'b11, 3'd5, 3'd0, 3'd0, 8'h22, 1'b0);
    idle();
    chk("st_pre", OUT_DATA[15:8], 8'h22);
    step(1'b1, 2'b11, 3'd5, 3'd0, 3'd0, 8'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11, 3'd4, 3'd0, 3'd0, 8'h99, 1'b1);
      chk("st_ready", IN_READY, 1'b0);
      chk("st_hold", OUT_DATA[15:8], 8'h22);
    end
    step(1'b1, 2'b11, 3'd4, 3'd0, 3'd0, 8'h99, 1'b0);
    chk("st_resume1", OUT_DATA[15:8], 8'h11);
    chk("st_resume_stb", OUT_STB, 2'b10);
    idle();
    chk("st_resume0", OUT_DATA[7:0], 8'h99);

    // Illegal address is sticky
    step(1'b1, 2'b11, 3'd7, 3'd0, 3'd0, 8'hAA, 1'b0);
    chk("ill_err", ERR, 1'b1);
    idle();
    chk("ill_nowrite", OUT_DATA, 16'h1199);
    step(1'b1, 2'b11, 3'd4, 3'd0, 3'd0, 8'h55, 1'b0);
    idle();
    chk("ill_sticky", ERR, 1'b1);
    chk("ill_later", OUT_DATA[7:0], 8'h55);
    do_reset();

    // Reset while an ADD is in flight
    step(1'b1, 2'b11, 3'd0, 3'd0, 3'd0, 8'h03, 1'b0);
    step(1'b1, 2'b11, 3'd1, 3'd0, 3'd0, 8'h04, 1'b0);
    step(1'b1, 2'b01, 3'd4, 3'd0, 3'd1, 8'h00, 1'b0);
    do_reset();
    idle();
    idle();
    chk("mid_rst_out0", OUT_DATA[7:0], 8'h00);
    chk("mid_rst_stb", OUT_STB, 2'b00);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      v  = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 99) < 15);
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) dst = 3'($urandom_range(4, 5));
      else dst = 3'($urandom_range(0, 3));
      sa = 3'($urandom_range(0, 3));
      sb = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) dst = 3'($urandom_range(6, 7));
      if ($urandom_range(0, 99) < 2) sa = 3'($urandom_range(4, 7));
      d = 8'($urandom);
      step(v, op, dst, sa, sb, d, st);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
